// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//
// First memory slave on the CPU request bus. It accepts a read or write
// request, stalls the core for WAIT_STATES extra cycles, then services the
// access against an internal synchronous byte RAM window. It returns read
// data and releases the stall. Every output is registered.
//
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   rst         in   asynchronous, active-low reset
//   req_rdwr    in   CPU requests an access
//   which_rdwr  in   read / write select (see ENUM__CPU_WH_RDWR__*)
//   addr        in   access address [ADDR_WIDTH]
//   data_out    in   CPU write data [DATA_WIDTH]
//   data_in     out  read data returned to the CPU [DATA_WIDTH]
//   enable      out  CPU clock-enable / ready, low stalls the core
//   oob_access  out  one-cycle pulse, completed access was outside the window
// ---------------------------------------------------------------------------

`ifndef ENUM__CPU_WH_RDWR__READ
`define ENUM__CPU_WH_RDWR__READ 1'b0
`endif
`ifndef ENUM__CPU_WH_RDWR__WRITE
`define ENUM__CPU_WH_RDWR__WRITE 1'b1
`endif

module cpu_mem_responder #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = 16'h0000,
  parameter int                    WAIT_STATES    = 1,
  parameter logic [DATA_WIDTH-1:0] OPEN_BUS       = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rdwr,
  input  logic                  which_rdwr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  enable,
  output logic                  oob_access
);

  localparam int         MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   dataIn_q, dataIn_d;
  logic                    enable_q, enable_d;
  logic                    oob_q, oob_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    memWe;
  logic                    memRe;
  logic                    inWindow;
  logic [MEM_ADDR_WIDTH-1:0] memIdx;

  // Window decode works on the latched address, so it is stable for the
  // whole transaction regardless of what the CPU does with its bus.
  assign inWindow = (addr_q[ADDR_WIDTH-1:MEM_ADDR_WIDTH] ==
                     MEM_BASE[ADDR_WIDTH-1:MEM_ADDR_WIDTH]);
  assign memIdx   = addr_q[MEM_ADDR_WIDTH-1:0];

  // Next-state and output logic. The RAM is only touched in ACCESS, so a
  // reset anywhere earlier drops the pending write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dataIn_d = dataIn_q;
    enable_d = enable_q;
    oob_d    = 1'b0;
    memWe    = 1'b0;
    memRe    = 1'b0;

    case (state_q)
      IDLE: begin
        enable_d = 1'b1;
        if (req_rdwr) begin
          wr_d     = (which_rdwr == `ENUM__CPU_WH_RDWR__WRITE);
          addr_d   = addr;
          wdata_d  = data_out;
          enable_d = 1'b0;
          cnt_d    = WAIT_INIT;
          state_d  = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end

      WAIT: begin
        enable_d = 1'b0;
        cnt_d    = cnt_q - 4'd1;
        // <= rather than == so a corrupted zero count cannot spin for 16 cycles
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        enable_d = 1'b0;
        memWe    = wr_q && inWindow;
        memRe    = !wr_q && inWindow;
        state_d  = DONE;
      end

      DONE: begin
        enable_d = 1'b1;
        oob_d    = !inWindow;
        // Writes leave the previously returned read data on the bus.
        if (!wr_q) begin
          dataIn_d = inWindow ? rdata_q : OPEN_BUS;
        end
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        enable_d = 1'b1;
        cnt_d    = 4'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dataIn_q <= '0;
      enable_q <= 1'b1;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dataIn_q <= dataIn_d;
      enable_q <= enable_d;
      oob_q    <= oob_d;
    end
  end

  // Synchronous byte RAM. Deliberately not reset so contents survive a
  // bus reset; the read port is registered and feeds DONE one cycle later.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memIdx] <= wdata_q;
    end
    if (memRe) begin
      rdata_q <= mem[memIdx];
    end
  end

  assign data_in    = dataIn_q;
  assign enable     = enable_q;
  assign oob_access = oob_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
//
// Three responders with WAIT_STATES 3, 1 and 0 are driven one at a time.
// Each access pushes its expected response (data, oob flag, stall length)
// onto a scoreboard queue; the entry is popped and compared when enable
// rises again.
// ---------------------------------------------------------------------------

`ifndef ENUM__CPU_WH_RDWR__READ
`define ENUM__CPU_WH_RDWR__READ 1'b0
`endif
`ifndef ENUM__CPU_WH_RDWR__WRITE
`define ENUM__CPU_WH_RDWR__WRITE 1'b1
`endif

module tb_cpu_mem_responder;

  typedef struct {
    logic [7:0] data;
    logic       oob;
    int         stall;
  } exp_t;

  logic             clk;
  logic [2:0]       rstN;
  logic [2:0]       req;
  logic [2:0]       wh;
  logic [2:0][15:0] addrV;
  logic [2:0][7:0]  doutV;
  wire  [2:0][7:0]  dinV;
  wire  [2:0]       en;
  wire  [2:0]       oob;

  exp_t       sbQ[$];
  logic [7:0] modelMem [3][4096];
  logic [7:0] lastData [3];
  int         testsRun;
  int         failCount;

  // Instance 0: 3 wait states, instance 1: 1 wait state, instance 2: none.
  for (genvar g = 0; g < 3; g++) begin : gDut
    cpu_mem_responder #(
      .WAIT_STATES(g == 0 ? 3 : (g == 1 ? 1 : 0))
    ) uDut (
      .clk       (clk),
      .rst       (rstN[g]),
      .req_rdwr  (req[g]),
      .which_rdwr(wh[g]),
      .addr      (addrV[g]),
      .data_out  (doutV[g]),
      .data_in   (dinV[g]),
      .enable    (en[g]),
      .oob_access(oob[g])
    );
  end

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int wsOf(input int idx);
    return (idx == 0) ? 3 : ((idx == 1) ? 1 : 0);
  endfunction

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one access on instance idx, predict its response, wait for enable
  // to return (bounded), then score it. keepReq leaves req_rdwr asserted so
  // the next call runs back-to-back.
  task automatic applyStimulus(input int idx, input bit isWrite,
                               input logic [15:0] a, input logic [7:0] d,
                               input bit keepReq);
    exp_t e;
    exp_t got;
    int   stall;
    bit   inWin;
    inWin = (a[15:12] == 4'h0);
    if (isWrite) begin
      if (inWin) modelMem[idx][a[11:0]] = d;
      e.data = lastData[idx];
    end else begin
      e.data = inWin ? modelMem[idx][a[11:0]] : 8'hFF;
      lastData[idx] = e.data;
    end
    e.oob   = !inWin;
    e.stall = wsOf(idx) + 2;
    sbQ.push_back(e);

    req[idx]   = 1'b1;
    wh[idx]    = isWrite ? `ENUM__CPU_WH_RDWR__WRITE : `ENUM__CPU_WH_RDWR__READ;
    addrV[idx] = a;
    doutV[idx] = d;

    @(posedge clk); #1;
    stall = 0;
    while (en[idx] == 1'b0 && stall < 40) begin
      stall++;
      @(posedge clk); #1;
    end
    if (!keepReq) req[idx] = 1'b0;

    got = sbQ.pop_front();
    checkOutput($sformatf("u%0d %s %h stall", idx, isWrite ? "wr" : "rd", a),
                stall, got.stall);
    checkOutput($sformatf("u%0d %s %h data_in", idx, isWrite ? "wr" : "rd", a),
                {24'd0, dinV[idx]}, {24'd0, got.data});
    checkOutput($sformatf("u%0d %s %h oob", idx, isWrite ? "wr" : "rd", a),
                {31'd0, oob[idx]}, {31'd0, got.oob});
    if (!keepReq) begin
      @(posedge clk); #1;
      checkOutput($sformatf("u%0d %h oob pulse end", idx, a), {31'd0, oob[idx]}, 32'd0);
      checkOutput($sformatf("u%0d %h enable idle", idx, a), {31'd0, en[idx]}, 32'd1);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rstN  = 3'b000;
    req   = 3'b000;
    wh    = 3'b000;
    addrV = '0;
    doutV = '0;
    for (int i = 0; i < 3; i++) lastData[i] = 8'h00;

    // Reset state of all three instances.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("u%0d reset enable", i), {31'd0, en[i]}, 32'd1);
      checkOutput($sformatf("u%0d reset data_in", i), {24'd0, dinV[i]}, 32'd0);
      checkOutput($sformatf("u%0d reset oob", i), {31'd0, oob[i]}, 32'd0);
    end
    @(negedge clk);
    rstN = 3'b111;
    @(posedge clk); #1;

    // Reset mid-wait on the 3-wait-state instance: the pending write is lost.
    applyStimulus(0, 1'b1, 16'h0010, 8'h33, 1'b0);
    req[0]   = 1'b1;
    wh[0]    = `ENUM__CPU_WH_RDWR__WRITE;
    addrV[0] = 16'h0010;
    doutV[0] = 8'h5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstN[0] = 1'b0;
    req[0]  = 1'b0;
    #1;
    checkOutput("u0 midwait reset enable", {31'd0, en[0]}, 32'd1);
    checkOutput("u0 midwait reset data_in", {24'd0, dinV[0]}, 32'd0);
    checkOutput("u0 midwait reset oob", {31'd0, oob[0]}, 32'd0);
    lastData[0] = 8'h00;
    @(negedge clk);
    rstN[0] = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 16'h0010, 8'h00, 1'b0);

    // Basic write/read with one wait state.
    applyStimulus(1, 1'b1, 16'h0123, 8'hA5, 1'b0);
    applyStimulus(1, 1'b0, 16'h0123, 8'h00, 1'b0);

    // Zero wait states.
    applyStimulus(2, 1'b1, 16'h0FFF, 8'h3C, 1'b0);
    applyStimulus(2, 1'b0, 16'h0FFF, 8'h00, 1'b0);

    // Out-of-window accesses, then confirm the window is untouched.
    applyStimulus(1, 1'b1, 16'h0000, 8'h4B, 1'b0);
    applyStimulus(1, 1'b0, 16'h1000, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 16'h8000, 8'h77, 1'b0);
    applyStimulus(1, 1'b0, 16'h0000, 8'h00, 1'b0);

    // Back-to-back reads with req_rdwr held high throughout.
    applyStimulus(1, 1'b1, 16'h0001, 8'h11, 1'b0);
    applyStimulus(1, 1'b1, 16'h0002, 8'h22, 1'b0);
    applyStimulus(1, 1'b0, 16'h0001, 8'h00, 1'b1);
    applyStimulus(1, 1'b0, 16'h0002, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("u1 after b2b enable %0d", i), {31'd0, en[1]}, 32'd1);
    end

    // A request raised only during DONE must be ignored.
    req[1]   = 1'b1;
    wh[1]    = `ENUM__CPU_WH_RDWR__READ;
    addrV[1] = 16'h0123;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req[1]   = 1'b1;
    wh[1]    = `ENUM__CPU_WH_RDWR__WRITE;
    doutV[1] = 8'hEE;
    @(posedge clk); #1;
    req[1] = 1'b0;
    lastData[1] = modelMem[1][12'h123];
    checkOutput("u1 done-req read enable", {31'd0, en[1]}, 32'd1);
    checkOutput("u1 done-req read data_in", {24'd0, dinV[1]}, {24'd0, modelMem[1][12'h123]});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("u1 done-req enable %0d", i), {31'd0, en[1]}, 32'd1);
    end
    applyStimulus(1, 1'b0, 16'h0123, 8'h00, 1'b0);

    checkOutput("scoreboard drained", sbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
